// File: rtl/keypad_encoder_seq.sv
// Keypad encoder: synchronises an N-key one-hot keypad, debounces it, rejects multi-key
// patterns, optionally auto-repeats, and drives the digit-load strobe or a divided tick.
//
// state      | meaning
// S_IDLE     | waiting for a single synchronised key while enabled
// S_DEBOUNCE | candidate captured, counting stable samples
// S_PRESSED  | key accepted, loadn low, optional auto-repeat running
// S_RELEASE  | counting all-zero samples before a new key may be taken
module keypad_encoder_seq #(
  parameter int NKEYS           = 10,
  parameter int DW              = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 0,
  parameter int TICK_DIV        = 100
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NKEYS-1:0] key,
  input  logic             enbn,
  output logic [DW-1:0]    D,
  output logic             loadn,
  output logic             pgt,
  output logic             strobe,
  output logic             multi,
  output logic             tick
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]    REP_LAST  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [TW-1:0]    TICK_PRE  = TW'(TICK_DIV - 2);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [NKEYS-1:0] KS_ONE    = NKEYS'(1);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  state_t           state, state_nx;
  logic [NKEYS-1:0] sync1, ks, cand, cand_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [RW-1:0]    rep, rep_nx;
  logic [DW-1:0]    d_nx, cand_idx;
  logic             strobe_nx;
  logic [TW-1:0]    div_cnt;
  logic             ks_single, ks_many;

  assign ks_many   = (ks & (ks - KS_ONE)) != '0;
  assign ks_single = (ks != '0) && !ks_many;

  always_comb begin
    cand_idx = '0;
    for (int i = 0; i < NKEYS; i++)
      if (cand[i]) cand_idx = DW'(i);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1  <= '0;
      ks     <= '0;
      state  <= S_IDLE;
      cand   <= '0;
      cnt    <= '0;
      rep    <= '0;
      D      <= '0;
      strobe <= 1'b0;
      multi  <= 1'b0;
    end else begin
      sync1  <= key;
      ks     <= sync1;
      state  <= state_nx;
      cand   <= cand_nx;
      cnt    <= cnt_nx;
      rep    <= rep_nx;
      D      <= d_nx;
      strobe <= strobe_nx;
      multi  <= ks_many;
    end
  end

  always_comb begin
    state_nx  = state;
    cand_nx   = cand;
    cnt_nx    = cnt;
    rep_nx    = rep;
    d_nx      = D;
    strobe_nx = 1'b0;
    if (enbn) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      rep_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ks_single) begin
            state_nx = S_DEBOUNCE;
            cand_nx  = ks;
            cnt_nx   = '0;
          end
        end
        S_DEBOUNCE: begin
          if (ks != cand) begin
            state_nx = S_IDLE;
          end else if (cnt == CNT_LAST) begin
            state_nx  = S_PRESSED;
            d_nx      = cand_idx;
            strobe_nx = 1'b1;
            rep_nx    = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        S_PRESSED: begin
          // a release or change takes priority over a coincident repeat point
          if (ks != cand) begin
            state_nx = S_RELEASE;
            cnt_nx   = '0;
          end else if (REPEAT_CYCLES > 0) begin
            if (rep == REP_LAST) begin
              strobe_nx = 1'b1;
              rep_nx    = '0;
            end else begin
              rep_nx = rep + RW'(1);
            end
          end
        end
        S_RELEASE: begin
          if (ks != '0)             cnt_nx = '0;
          else if (cnt == CNT_LAST) state_nx = S_IDLE;
          else                      cnt_nx = cnt + CW'(1);
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // free-running divider; tick is registered so it is high while div_cnt == TICK_DIV-1
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == TICK_LAST) ? '0 : div_cnt + TW'(1);
      tick    <= (div_cnt == TICK_PRE);
    end
  end

  assign loadn = (state != S_PRESSED);
  assign pgt   = enbn ? tick : strobe;

endmodule

// File: tb/tb_keypad_encoder_seq.sv
// Randomised bench for keypad_encoder_seq: a default instance and an auto-repeat instance
// share stimulus and are compared every cycle against a run-length reference model.
module tb_keypad_encoder_seq;
  localparam int NKEYS = 10;
  localparam int DW    = 4;
  localparam int DC    = 4;
  localparam int TD    = 100;

  logic             clk  = 1'b0;
  logic             rstn = 1'b1;
  logic [NKEYS-1:0] key  = '0;
  logic             enbn = 1'b0;
  logic [DW-1:0]    d_a, d_b;
  logic             loadn_a, pgt_a, strobe_a, multi_a, tick_a;
  logic             loadn_b, pgt_b, strobe_b, multi_b, tick_b;

  always #5 clk = ~clk;

  keypad_encoder_seq #(.NKEYS(NKEYS), .DW(DW), .DEBOUNCE_CYCLES(DC),
                       .REPEAT_CYCLES(0), .TICK_DIV(TD)) u_dut (
    .clk(clk), .rstn(rstn), .key(key), .enbn(enbn), .D(d_a), .loadn(loadn_a),
    .pgt(pgt_a), .strobe(strobe_a), .multi(multi_a), .tick(tick_a));

  keypad_encoder_seq #(.NKEYS(NKEYS), .DW(DW), .DEBOUNCE_CYCLES(DC),
                       .REPEAT_CYCLES(10), .TICK_DIV(TD)) u_rep (
    .clk(clk), .rstn(rstn), .key(key), .enbn(enbn), .D(d_b), .loadn(loadn_b),
    .pgt(pgt_b), .strobe(strobe_b), .multi(multi_b), .tick(tick_b));

  int n_cmp = 0;
  int n_mis = 0;

  // reference model: phase 0 free, 1 qualifying, 2 held, 3 waiting for full release
  int               ph[2], stable[2], quiet[2], held[2], d_m[2];
  int               rep_cyc[2] = '{0, 10};
  logic [NKEYS-1:0] cand[2];
  bit               strobe_m[2];
  bit               multi_m, tick_m;
  logic [NKEYS-1:0] m_s1, m_ks;
  int               n_edge;
  int               strobe_cnt_a, strobe_cnt_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int key_idx(input logic [NKEYS-1:0] v);
    for (int i = 0; i < NKEYS; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; stable[k] = 0; quiet[k] = 0; held[k] = 0; d_m[k] = 0;
      cand[k] = '0; strobe_m[k] = 0;
    end
    multi_m = 0; tick_m = 0; m_s1 = '0; m_ks = '0; n_edge = 0;
  endtask

  task automatic model_edge();
    logic [NKEYS-1:0] v;
    v = m_ks;
    n_edge++;
    tick_m  = (n_edge % TD) == TD - 1;
    multi_m = $countones(v) > 1;
    for (int k = 0; k < 2; k++) begin
      strobe_m[k] = 0;
      if (enbn) ph[k] = 0;
      else case (ph[k])
        0: if ($countones(v) == 1) begin ph[k] = 1; cand[k] = v; stable[k] = 0; end
        1: if (v != cand[k]) ph[k] = 0;
           else begin
             stable[k]++;
             if (stable[k] == DC) begin
               ph[k] = 2; d_m[k] = key_idx(v); strobe_m[k] = 1; held[k] = 0;
             end
           end
        2: if (v != cand[k]) begin ph[k] = 3; quiet[k] = 0; end
           else begin
             held[k]++;
             if (rep_cyc[k] > 0 && held[k] % rep_cyc[k] == 0) strobe_m[k] = 1;
           end
        default: if (v != '0) quiet[k] = 0;
                 else begin quiet[k]++; if (quiet[k] == DC) ph[k] = 0; end
      endcase
    end
    m_ks = m_s1;
    m_s1 = key;
  endtask

  task automatic check_outputs();
    check_eq("strobe_a", strobe_a, strobe_m[0]);
    check_eq("d_a",      d_a,      d_m[0]);
    check_eq("loadn_a",  loadn_a,  ph[0] != 2);
    check_eq("multi_a",  multi_a,  multi_m);
    check_eq("tick_a",   tick_a,   tick_m);
    check_eq("pgt_a",    pgt_a,    enbn ? tick_m : strobe_m[0]);
    check_eq("strobe_b", strobe_b, strobe_m[1]);
    check_eq("d_b",      d_b,      d_m[1]);
    check_eq("loadn_b",  loadn_b,  ph[1] != 2);
    check_eq("multi_b",  multi_b,  multi_m);
    check_eq("tick_b",   tick_b,   tick_m);
    check_eq("pgt_b",    pgt_b,    enbn ? tick_m : strobe_m[1]);
  endtask

  task automatic step(input logic [NKEYS-1:0] kv, input logic ev);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (strobe_a) strobe_cnt_a++;
    if (strobe_b) strobe_cnt_b++;
    key  = kv;
    enbn = ev;
    #1;
    check_eq("pgt_mux_a", pgt_a, ev ? tick_m : strobe_m[0]);
    check_eq("pgt_mux_b", pgt_b, ev ? tick_m : strobe_m[1]);
  endtask

  task automatic do_reset();
    #1 rstn = 1'b0;
    #1;
    check_eq("rst_d",      {d_a, d_b}, 0);
    check_eq("rst_loadn",  {loadn_a, loadn_b}, 2'b11);
    check_eq("rst_strobe", {strobe_a, strobe_b}, 0);
    check_eq("rst_multi",  {multi_a, multi_b}, 0);
    check_eq("rst_tick",   {tick_a, tick_b}, 0);
    check_eq("rst_pgt",    {pgt_a, pgt_b}, 0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    model_reset();
  endtask

  function automatic logic [NKEYS-1:0] bitk(input int i);
    logic [NKEYS-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [NKEYS-1:0] kv;
    logic [4:0]       bounce;
    int               len;
    bit               ev;

    model_reset();
    do_reset();

    // key 7 stable for 20 cycles, then released
    strobe_cnt_a = 0;
    for (int i = 0; i < 20; i++) step(bitk(7), 1'b0);
    for (int i = 0; i < 12; i++) step('0, 1'b0);
    check_eq("k7_strobes", strobe_cnt_a, 1);
    check_eq("k7_d", d_a, 7);

    // key 3 bounces 1,0,1,1,0 then settles
    strobe_cnt_a = 0;
    bounce = 5'b10110;
    for (int i = 4; i >= 0; i--) step(bounce[i] ? bitk(3) : '0, 1'b0);
    check_eq("bounce_nostrobe", strobe_cnt_a, 0);
    for (int i = 0; i < 15; i++) step(bitk(3), 1'b0);
    for (int i = 0; i < 12; i++) step('0, 1'b0);
    check_eq("k3_strobes", strobe_cnt_a, 1);
    check_eq("k3_d", d_a, 3);

    // keys 2 and 5 together are never accepted
    strobe_cnt_a = 0;
    for (int i = 0; i < 30; i++) step(bitk(2) | bitk(5), 1'b0);
    check_eq("multi_flag", multi_a, 1);
    for (int i = 0; i < 12; i++) step('0, 1'b0);
    check_eq("multi_nostrobe", strobe_cnt_a, 0);
    check_eq("multi_d", d_a, 3);

    // key 9 held 40 cycles: four strobes on the repeat instance, one on the default
    strobe_cnt_a = 0;
    strobe_cnt_b = 0;
    for (int i = 0; i < 40; i++) step(bitk(9), 1'b0);
    for (int i = 0; i < 12; i++) step('0, 1'b0);
    check_eq("k9_strobes_a", strobe_cnt_a, 1);
    check_eq("k9_strobes_b", strobe_cnt_b, 4);
    check_eq("k9_d_b", d_b, 9);

    // disabled: tick on pgt, random keys never strobe
    strobe_cnt_a = 0;
    for (int i = 0; i < 350; i++)
      step(($urandom_range(0, 3) == 0) ? bitk($urandom_range(0, NKEYS - 1)) : '0, 1'b1);
    check_eq("dis_nostrobe", strobe_cnt_a, 0);
    for (int i = 0; i < 12; i++) step('0, 1'b0);

    // reset while pressed; held key must debounce again
    for (int i = 0; i < 10; i++) step(bitk(6), 1'b0);
    check_eq("pre_rst_loadn", loadn_a, 0);
    do_reset();
    strobe_cnt_a = 0;
    for (int i = 0; i < 12; i++) step(bitk(6), 1'b0);
    check_eq("post_rst_strobes", strobe_cnt_a, 1);
    check_eq("post_rst_d", d_a, 6);
    for (int i = 0; i < 12; i++) step('0, 1'b0);

    // random key patterns with short glitches, multi-key and occasional disable
    for (int s = 0; s < 250; s++) begin
      case ($urandom_range(0, 9))
        0, 1:    kv = '0;
        8, 9:    kv = bitk($urandom_range(0, NKEYS - 1)) | bitk($urandom_range(0, NKEYS - 1));
        default: kv = bitk($urandom_range(0, NKEYS - 1));
      endcase
      len = $urandom_range(1, 14);
      ev  = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < len; i++) step(kv, ev);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/keypad_encoder_seq.md
# keypad_encoder_seq

Parametrised, fully synchronous successor to the microwave keypad encoder. Converts an N-key one-hot keypad into a binary digit code with counter-based debounce, multi-key rejection and optional auto-repeat. Produces the digit-load strobe `pgt`, which carries key strobes when enabled and a free-running divided tick when disabled. Sits between the front-panel keypad and the digit-entry/timer registers, clocked from the system clock.

## Interface
- `NKEYS`, 10: number of keypad inputs (2..64).
- `DW`, 4: code width; must satisfy 2^DW >= NKEYS.
- `DEBOUNCE_CYCLES`, 4: consecutive stable samples required for press and for release (>=1).
- `REPEAT_CYCLES`, 0: auto-repeat period in cycles while held; 0 disables repeat.
- `TICK_DIV`, 100: divider period for `tick` (>=2).

- `clk`  in  1  system clock, rising-edge.
- `rstn`  in  1  asynchronous active-low reset.
- `key`  in  NKEYS  raw keypad lines, active-high, asynchronous to `clk`.
- `enbn`  in  1  active-low enable; 1 = keypad ignored, `pgt` follows `tick`.
- `D`  out  DW  index of last accepted key; holds between presses.
- `loadn`  out  1  low while a debounced valid key is held (state PRESSED).
- `pgt`  out  1  load strobe: `enbn` ? `tick` : `strobe`.
- `strobe`  out  1  one-cycle pulse per accepted press or repeat.
- `multi`  out  1  high while more than one synchronised key is active.
- `tick`  out  1  one-cycle pulse every TICK_DIV cycles, free-running.

## Operation
- Reset (`rstn`=0, immediate): state IDLE, `D`=0, `loadn`=1, `strobe`=0, `multi`=0, `tick`=0, all counters 0, synchroniser flops 0; `pgt`=0.
- `key` passes a 2-flop synchroniser -> `ks`. `ks` valid = exactly one bit set; index = that bit position.
- `multi` registered from `ks` popcount > 1. A multi-key pattern is never accepted.
- FSM:
  - IDLE: `ks` valid and `enbn`=0 -> DEBOUNCE, capture `cand`=`ks`, cnt=0.
  - DEBOUNCE: `ks`!=`cand` -> IDLE. Else cnt++; on cnt = DEBOUNCE_CYCLES-1 -> PRESSED, `D`<=index(`cand`), `strobe`<=1, rep=0.
  - PRESSED: `loadn`=0. `ks`!=`cand` (release, change or added key) -> RELEASE, cnt=0. If REPEAT_CYCLES>0: rep++; on rep = REPEAT_CYCLES-1 pulse `strobe`, rep=0.
  - RELEASE: `ks`=0 increments cnt, nonzero clears cnt; on cnt = DEBOUNCE_CYCLES-1 -> IDLE. A new key requires full release first (no rollover).
- `enbn`=1 in any state -> IDLE at next edge, no strobe issued, `D` holds, `loadn`=1.
- Divider: cnt 0..TICK_DIV-1 wraps; `tick`=1 in the cycle cnt=TICK_DIV-1. Unaffected by `enbn` and FSM.
- `pgt` is a combinational 2:1 mux of registered `tick`/`strobe` selected by `enbn`.

## Timing
- Let edge E0 be the first edge sampling a stable single key. `ks` valid after E1; DEBOUNCE entered at E2; PRESSED entered, `D` updated, `strobe` high, `loadn` low after edge E(2+DEBOUNCE_CYCLES). Default: strobe during cycle after E6.
- `strobe` is exactly 1 cycle wide; the initial strobe and repeat strobes are never adjacent (repeat strobes start REPEAT_CYCLES cycles after the initial strobe).
- `loadn` returns high at the edge leaving PRESSED (the edge after the first mismatching `ks`).
- Glitch shorter than DEBOUNCE_CYCLES samples: no strobe, `D` unchanged.
- Simultaneous release and repeat point: release wins, no strobe.
- Reset mid-press: outputs to reset values immediately; after reset a still-held key must debounce afresh.
- `enbn` toggling changes `pgt` source combinationally in the same cycle.

## Test plan
- Press key 7 stable 20 cycles, `enbn`=0 -> single `strobe`/`pgt` pulse at E6, `D`=7, `loadn`=0 until 2 cycles after release.
- Key 3 bounce pattern 1,0,1,1,0 then stable -> no strobe during bounce; exactly one strobe after 4 stable samples, `D`=3.
- Keys 2 and 5 together 30 cycles -> `multi`=1, no strobe, `D` unchanged, `loadn`=1.
- REPEAT_CYCLES=10, hold key 9 for 40 cycles -> strobes at t, t+10, t+20, t+30; `D`=9 throughout.
- `enbn`=1, no keys, 350 cycles -> `tick`/`pgt` pulse every 100 cycles starting cycle 99; key presses produce no strobe.
- `rstn` pulsed low while in PRESSED -> `loadn`=1, `D`=0 immediately; held key re-accepted after full debounce.
